// File: rtl/id_ex_hazard_reg_pkg.sv
// pipe_pkg: shared control bundle, hazard FSM states and opcode constants for the ID/EX stage.
package pipe_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
    } ctrl_t;

    typedef enum logic {RUN, HOLD2} hz_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b0;
    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// id_ex_hazard_reg_if: decoded ID fields in, registered EX fields and hazard controls out.
interface id_ex_hazard_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    import pipe_pkg::*;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [5:0]        id_op_c;
    logic [DATA_W-1:0] id_read1, id_read2, id_imm;
    ctrl_t             id_ctrl;
    logic              id_uses_rt, id_is_branch, flush_id;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd, ex_dest;
    logic [5:0]        ex_op_c;
    logic [DATA_W-1:0] ex_read1, ex_read2, ex_imm;
    ctrl_t             ex_ctrl;
    logic              pc_write, if_id_write, stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_rs, id_rt, id_rd, id_op_c, id_read1, id_read2, id_imm, id_ctrl,
               id_uses_rt, id_is_branch, flush_id,
        input  ex_rs, ex_rt, ex_rd, ex_dest, ex_op_c, ex_read1, ex_read2, ex_imm, ex_ctrl,
               pc_write, if_id_write, stall, stall_count
    );
    modport slave (
        input  id_rs, id_rt, id_rd, id_op_c, id_read1, id_read2, id_imm, id_ctrl,
               id_uses_rt, id_is_branch, flush_id,
        output ex_rs, ex_rt, ex_rd, ex_dest, ex_op_c, ex_read1, ex_read2, ex_imm, ex_ctrl,
               pc_write, if_id_write, stall, stall_count
    );
endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// hazard_detect: combinational load-use and branch-operand hazard terms from the EX destination.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    output logic             load_use,
    output logic             br_alu,
    output logic             br_load
);
    logic match_ex;

    always_comb begin
        match_ex = ex_reg_write && ex_dest != '0 &&
                   (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
        load_use = match_ex && ex_mem_read && !id_is_branch;
        br_alu   = match_ex && id_is_branch && !ex_mem_read;
        br_load  = match_ex && id_is_branch && ex_mem_read;
    end
endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with bubble insertion, PC/IF-ID hold and a saturating stall counter.
module id_ex_hazard_reg
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    id_ex_hazard_reg_if.slave bus
);
    hz_state_t state, state_next;
    logic load_use, br_alu, br_load, hazard, stall_c, bubble;

    hazard_detect #(.REG_W(REG_W)) u_hd (
        .ex_reg_write (bus.ex_ctrl.reg_write),
        .ex_mem_read  (bus.ex_ctrl.mem_read),
        .ex_dest      (bus.ex_dest),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_uses_rt   (bus.id_uses_rt),
        .id_is_branch (bus.id_is_branch),
        .load_use     (load_use),
        .br_alu       (br_alu),
        .br_load      (br_load)
    );

    assign bus.ex_dest = bus.ex_ctrl.reg_dst ? bus.ex_rd : bus.ex_rt;

    // HOLD2 is the second bubble of a branch-on-load and ignores flush_id.
    always_comb begin
        hazard     = load_use | br_alu;
        stall_c    = (state == HOLD2) | (!bus.flush_id & (hazard | br_load));
        bubble     = stall_c | bus.flush_id;
        state_next = (state == RUN && !bus.flush_id && !hazard && br_load) ? HOLD2 : RUN;
    end

    assign bus.stall       = !rst & stall_c;
    assign bus.pc_write    = rst | !stall_c;
    assign bus.if_id_write = rst | !stall_c;

    always_ff @(posedge clk) begin
        state <= rst ? RUN : state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.ex_rs    <= '0;
            bus.ex_rt    <= '0;
            bus.ex_rd    <= '0;
            bus.ex_op_c  <= OP_RTYPE;
            bus.ex_read1 <= '0;
            bus.ex_read2 <= '0;
            bus.ex_imm   <= '0;
            bus.ex_ctrl  <= CTRL_BUBBLE;
        end else begin
            bus.ex_rs    <= bus.id_rs;
            bus.ex_rt    <= bus.id_rt;
            bus.ex_rd    <= bus.id_rd;
            bus.ex_op_c  <= bus.id_op_c;
            bus.ex_read1 <= bus.id_read1;
            bus.ex_read2 <= bus.id_read2;
            bus.ex_imm   <= bus.id_imm;
            bus.ex_ctrl  <= bus.id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus.stall_count <= '0;
        else if (stall_c && bus.stall_count != '1)
            bus.stall_count <= bus.stall_count + CNT_W'(1);
    end
endmodule
